// File: rtl/sample_voice_scheduler.sv
// Four-voice sample playback scheduler: fetches one byte per active voice
// each 48 kHz frame over a shared read port and mixes them into a 16-bit output.
module sample_voice_scheduler #(
   parameter int AW = 16,
   parameter int NV = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clk_48KHz_en,
   input  logic          sound_enable,
   input  logic [NV-1:0] trig,
   input  logic [NV-1:0] loop,
   input  logic          cfg_wr,
   input  logic [1:0]    cfg_voice,
   input  logic [AW-1:0] cfg_start,
   input  logic [AW-1:0] cfg_len,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [7:0]    mem_data,
   output logic [15:0]   out,
   output logic [NV-1:0] busy,
   output logic          overrun
);

   localparam int VW = $clog2(NV);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ARM  = 3'd1;
   localparam logic [2:0] S_REQ  = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_NEXT = 3'd4;
   localparam logic [2:0] S_MIX  = 3'd5;

   localparam logic [AW-1:0] ONE   = AW'(1);
   localparam logic [VW-1:0] VONE  = VW'(1);
   localparam logic [VW-1:0] VLAST = VW'(NV - 1);

   logic [2:0]    state_q, state_d;
   logic [VW-1:0] v_q, v_d;
   logic [AW-1:0] start_q [NV];
   logic [AW-1:0] start_d [NV];
   logic [AW-1:0] len_q [NV];
   logic [AW-1:0] len_d [NV];
   logic [AW-1:0] pos_q [NV];
   logic [AW-1:0] pos_d [NV];
   logic [7:0]    smp_q [NV];
   logic [7:0]    smp_d [NV];
   logic [NV-1:0] active_q, active_d;
   logic [NV-1:0] pending_q, pending_d;
   logic [NV-1:0] trig_q;
   logic [NV-1:0] trig_rise;
   logic          mem_req_q, mem_req_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [15:0]   out_q, out_d;
   logic          overrun_q, overrun_d;
   logic [9:0]    mix_sum;

   assign trig_rise = trig & ~trig_q;

   always_comb begin
      mix_sum = '0;
      for (int i = 0; i < NV; i++) begin
         mix_sum = mix_sum + {2'b00, smp_q[i]};
      end
   end

   always_comb begin
      state_d    = state_q;
      v_d        = v_q;
      start_d    = start_q;
      len_d      = len_q;
      pos_d      = pos_q;
      smp_d      = smp_q;
      active_d   = active_q;
      pending_d  = pending_q | trig_rise;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      out_d      = out_q;
      overrun_d  = overrun_q;

      if (cfg_wr) begin
         start_d[cfg_voice] = cfg_start;
         len_d[cfg_voice]   = cfg_len;
      end

      if (clk_48KHz_en && state_q != S_IDLE) begin
         overrun_d = 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (clk_48KHz_en && sound_enable) begin
               state_d = S_ARM;
               v_d     = '0;
            end
         end
         S_ARM: begin
            for (int i = 0; i < NV; i++) begin
               if (pending_q[i] && len_q[i] != '0) begin
                  pos_d[i]    = '0;
                  active_d[i] = 1'b1;
               end
            end
            // an edge landing in this very cycle must survive the clear
            pending_d = trig_rise;
            state_d   = S_REQ;
         end
         S_REQ: begin
            if (active_q[v_q]) begin
               mem_req_d  = 1'b1;
               mem_addr_d = start_q[v_q] + pos_q[v_q];
               state_d    = S_WAIT;
            end else begin
               smp_d[v_q] = '0;
               state_d    = S_NEXT;
            end
         end
         S_WAIT: begin
            if (mem_ack) begin
               smp_d[v_q] = mem_data;
               mem_req_d  = 1'b0;
               state_d    = S_NEXT;
            end
         end
         S_NEXT: begin
            if (pos_q[v_q] == len_q[v_q] - ONE) begin
               if (loop[v_q]) pos_d[v_q] = '0;
               else           active_d[v_q] = 1'b0;
            end else begin
               pos_d[v_q] = pos_q[v_q] + ONE;
            end
            if (v_q == VLAST) begin
               state_d = S_MIX;
            end else begin
               v_d     = v_q + VONE;
               state_d = S_REQ;
            end
         end
         S_MIX: begin
            out_d   = {mix_sum, 6'b0};
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // muting lets an in-flight read finish before parking in IDLE
      if (!sound_enable) begin
         active_d  = '0;
         pending_d = '0;
         out_d     = '0;
         if (state_q != S_WAIT || mem_ack) begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         v_q        <= '0;
         active_q   <= '0;
         pending_q  <= '0;
         trig_q     <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         out_q      <= '0;
         overrun_q  <= 1'b0;
         for (int i = 0; i < NV; i++) begin
            start_q[i] <= '0;
            len_q[i]   <= '0;
            pos_q[i]   <= '0;
            smp_q[i]   <= '0;
         end
      end else begin
         state_q    <= state_d;
         v_q        <= v_d;
         active_q   <= active_d;
         pending_q  <= pending_d;
         trig_q     <= trig;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         out_q      <= out_d;
         overrun_q  <= overrun_d;
         for (int i = 0; i < NV; i++) begin
            start_q[i] <= start_d[i];
            len_q[i]   <= len_d[i];
            pos_q[i]   <= pos_d[i];
            smp_q[i]   <= smp_d[i];
         end
      end
   end

   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;
   assign out      = out_q;
   assign busy     = active_q;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_sample_voice_scheduler.sv
// Bench for sample_voice_scheduler: directed scenarios plus random frames
// checked against a per-frame behavioural model of the voice scheduler.
module tb_sample_voice_scheduler;

   logic        clk = 1'b0;
   logic        rst, tick, sound_enable, cfg_wr;
   logic [3:0]  trig, loop;
   logic [1:0]  cfg_voice;
   logic [15:0] cfg_start, cfg_len;
   logic        mem_req, mem_ack, overrun;
   logic [15:0] mem_addr, out;
   logic [7:0]  mem_data;
   logic [3:0]  busy;

   always #5 clk = ~clk;

   sample_voice_scheduler #(.AW(16), .NV(4)) dut (
      .clk(clk), .rst(rst), .clk_48KHz_en(tick),
      .sound_enable(sound_enable), .trig(trig), .loop(loop),
      .cfg_wr(cfg_wr), .cfg_voice(cfg_voice),
      .cfg_start(cfg_start), .cfg_len(cfg_len),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_data(mem_data),
      .out(out), .busy(busy), .overrun(overrun)
   );

   typedef logic [15:0] aq_t[$];

   logic [7:0]  mem [0:65535];
   aq_t         seen;
   int          ack_dly = 1;
   bit          stall = 0;
   int          stab_err = 0;
   int          tests = 0;
   int          fails = 0;

   logic [15:0] m_start [4];
   logic [15:0] m_len [4];
   int          m_pos [4];
   logic [3:0]  m_act, m_pend;

   logic [15:0] r_a;
   int          r_n;

   // memory slave: logs each request, acks after ack_dly cycles unless stalled
   initial begin
      mem_ack  = 1'b0;
      mem_data = '0;
      forever begin
         @(posedge clk); #1;
         if (mem_req === 1'b1) begin
            r_a = mem_addr;
            seen.push_back(r_a);
            r_n = 1;
            while (r_n < ack_dly || stall) begin
               if (mem_req !== 1'b1 || mem_addr !== r_a) stab_err++;
               @(posedge clk); #1;
               r_n++;
            end
            mem_ack  = 1'b1;
            mem_data = mem[r_a];
            @(posedge clk); #1;
            mem_ack  = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: sim time exceeded, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   function automatic bit same_q(aq_t a, aq_t b);
      if (a.size() != b.size()) return 1'b0;
      foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_clear();
      for (int v = 0; v < 4; v++) begin
         m_start[v] = '0;
         m_len[v]   = '0;
         m_pos[v]   = 0;
      end
      m_act  = '0;
      m_pend = '0;
   endtask

   // one frame of the voice rules: arm, read each live voice, advance, mix
   task automatic model_frame(output aq_t ea, output logic [15:0] eo,
                              output logic [3:0] eb);
      int sum = 0;
      logic [15:0] a;
      ea = {};
      for (int v = 0; v < 4; v++) begin
         if (m_pend[v] && m_len[v] != 0) begin
            m_act[v] = 1'b1;
            m_pos[v] = 0;
         end
      end
      m_pend = '0;
      for (int v = 0; v < 4; v++) begin
         if (m_act[v]) begin
            a = 16'(int'(m_start[v]) + m_pos[v]);
            ea.push_back(a);
            sum += int'(mem[a]);
            if (m_pos[v] + 1 == int'(m_len[v])) begin
               if (loop[v]) m_pos[v] = 0;
               else m_act[v] = 1'b0;
            end else begin
               m_pos[v]++;
            end
         end
      end
      eo = 16'(sum * 64);
      eb = m_act;
   endtask

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; tick = 1'b0; sound_enable = 1'b1;
      trig = '0; loop = '0; cfg_wr = 1'b0;
      cfg_voice = '0; cfg_start = '0; cfg_len = '0;
      stall = 0; ack_dly = 1;
      cyc(3);
      rst = 1'b0;
      cyc(1);
      model_clear();
      stab_err = 0;
   endtask

   task automatic cfg(int v, logic [15:0] s, logic [15:0] l);
      cfg_wr = 1'b1;
      cfg_voice = 2'(v);
      cfg_start = s;
      cfg_len = l;
      cyc(1);
      cfg_wr = 1'b0;
      m_start[v] = s;
      m_len[v] = l;
   endtask

   task automatic pulse_trig(logic [3:0] mask);
      trig = trig | mask;
      cyc(1);
      trig = trig & ~mask;
      cyc(1);
   endtask

   task automatic tick_pulse();
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
   endtask

   task automatic wait_done();
      int idle = 0;
      int n = 0;
      while (idle < 14 && n < 2000) begin
         cyc(1);
         n++;
         if (mem_req || mem_ack) idle = 0;
         else idle++;
      end
      tests++;
      if (n >= 2000) begin
         fails++;
         $display("FAIL frame_timeout: mem_req=%b after %0d cycles, want idle", mem_req, n);
      end
   endtask

   task automatic wait_req();
      int n = 0;
      while (mem_req !== 1'b1 && n < 200) begin
         cyc(1);
         n++;
      end
      tests++;
      if (mem_req !== 1'b1) begin
         fails++;
         $display("FAIL req_timeout: mem_req=%b, want 1", mem_req);
      end
   endtask

   task automatic run_frame();
      seen.delete();
      tick_pulse();
      wait_done();
   endtask

   task automatic test_reset();
      aq_t ea;
      logic [15:0] eo;
      logic [3:0] eb;
      do_reset();
      tests++;
      if (out !== 16'h0 || busy !== 4'h0 || mem_req !== 1'b0 ||
          mem_addr !== 16'h0 || overrun !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: out=%h busy=%b req=%b addr=%h ovr=%b, want all 0",
                  out, busy, mem_req, mem_addr, overrun);
      end
      pulse_trig(4'b0001);
      m_pend |= 4'b0001;
      run_frame();
      model_frame(ea, eo, eb);
      tests++;
      if (!same_q(seen, ea) || out !== eo || busy !== eb) begin
         fails++;
         $display("FAIL reset_len0: addr=%p out=%h busy=%b, want addr=%p out=%h busy=%b",
                  seen, out, busy, ea, eo, eb);
      end
   endtask

   task automatic test_single_voice();
      aq_t ea;
      logic [15:0] eo;
      logic [3:0] eb;
      logic [15:0] kout [4] = '{16'h0400, 16'h0800, 16'h0C00, 16'h0000};
      logic kb [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      do_reset();
      ack_dly = 2;
      mem[16'h0100] = 8'h10;
      mem[16'h0101] = 8'h20;
      mem[16'h0102] = 8'h30;
      cfg(0, 16'h0100, 16'd3);
      pulse_trig(4'b0001);
      m_pend |= 4'b0001;
      for (int f = 0; f < 4; f++) begin
         run_frame();
         model_frame(ea, eo, eb);
         tests++;
         if (!same_q(seen, ea) || out !== eo || busy !== eb) begin
            fails++;
            $display("FAIL single_f%0d: addr=%p out=%h busy=%b, want addr=%p out=%h busy=%b",
                     f, seen, out, busy, ea, eo, eb);
         end
         tests++;
         if (out !== kout[f] || busy[0] !== kb[f]) begin
            fails++;
            $display("FAIL single_const_f%0d: out=%h busy0=%b, want out=%h busy0=%b",
                     f, out, busy[0], kout[f], kb[f]);
         end
      end
   endtask

   task automatic test_loop();
      aq_t ea;
      logic [15:0] eo;
      logic [3:0] eb;
      do_reset();
      mem[16'h2000] = 8'hFF;
      mem[16'h2001] = 8'h01;
      cfg(2, 16'h2000, 16'd2);
      loop = 4'b0100;
      pulse_trig(4'b0100);
      m_pend |= 4'b0100;
      for (int f = 0; f < 9; f++) begin
         if (f == 6) loop = 4'b0000;
         run_frame();
         model_frame(ea, eo, eb);
         tests++;
         if (!same_q(seen, ea) || out !== eo || busy !== eb) begin
            fails++;
            $display("FAIL loop_f%0d: addr=%p out=%h busy=%b, want addr=%p out=%h busy=%b",
                     f, seen, out, busy, ea, eo, eb);
         end
         if (f < 6) begin
            tests++;
            if (seen.size() != 1 || seen[0] !== 16'(16'h2000 + f % 2) || busy[2] !== 1'b1) begin
               fails++;
               $display("FAIL loop_const_f%0d: n=%0d busy2=%b, want addr=%h busy2=1",
                        f, seen.size(), busy[2], 16'(16'h2000 + f % 2));
            end
         end
      end
      tests++;
      if (busy[2] !== 1'b0) begin
         fails++;
         $display("FAIL loop_end: busy2=%b, want 0", busy[2]);
      end
   endtask

   task automatic test_full_mix();
      aq_t ea;
      logic [15:0] eo;
      logic [3:0] eb;
      do_reset();
      ack_dly = 3;
      for (int v = 0; v < 4; v++) begin
         mem[16'(16'h4000 + 16 * v)] = 8'hFF;
         cfg(v, 16'(16'h4000 + 16 * v), 16'd1);
      end
      pulse_trig(4'b1111);
      m_pend |= 4'b1111;
      for (int f = 0; f < 2; f++) begin
         run_frame();
         model_frame(ea, eo, eb);
         tests++;
         if (!same_q(seen, ea) || out !== eo || busy !== eb) begin
            fails++;
            $display("FAIL fullmix_f%0d: addr=%p out=%h busy=%b, want addr=%p out=%h busy=%b",
                     f, seen, out, busy, ea, eo, eb);
         end
         if (f == 0) begin
            tests++;
            if (out !== 16'hFF00) begin
               fails++;
               $display("FAIL fullmix_max: out=%h, want ff00", out);
            end
         end
      end
   endtask

   task automatic test_overrun();
      aq_t ea;
      logic [15:0] eo;
      logic [3:0] eb;
      do_reset();
      mem[16'h5000] = 8'h42;
      cfg(1, 16'h5000, 16'd1);
      pulse_trig(4'b0010);
      m_pend |= 4'b0010;
      stall = 1;
      seen.delete();
      tick_pulse();
      wait_req();
      cyc(30);
      tick_pulse();
      cyc(30);
      tests++;
      if (overrun !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 16'h5000 || stab_err != 0) begin
         fails++;
         $display("FAIL overrun_set: ovr=%b req=%b addr=%h unstable=%0d, want 1 1 5000 0",
                  overrun, mem_req, mem_addr, stab_err);
      end
      stall = 0;
      wait_done();
      model_frame(ea, eo, eb);
      tests++;
      if (!same_q(seen, ea) || out !== eo || busy !== eb || overrun !== 1'b1) begin
         fails++;
         $display("FAIL overrun_frame: addr=%p out=%h busy=%b ovr=%b, want addr=%p out=%h busy=%b ovr=1",
                  seen, out, busy, overrun, ea, eo, eb);
      end
      do_reset();
      tests++;
      if (overrun !== 1'b0) begin
         fails++;
         $display("FAIL overrun_clear: ovr=%b, want 0", overrun);
      end
   endtask

   task automatic test_rst_wait();
      int reqs = 0;
      do_reset();
      mem[16'h0600] = 8'h77;
      cfg(0, 16'h0600, 16'd2);
      pulse_trig(4'b0001);
      stall = 1;
      tick_pulse();
      wait_req();
      cyc(3);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      tests++;
      if (mem_req !== 1'b0) begin
         fails++;
         $display("FAIL rst_wait_drop: mem_req=%b, want 0", mem_req);
      end
      stall = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(1);
         if (mem_req) reqs++;
      end
      tests++;
      if (reqs != 0 || out !== 16'h0 || busy !== 4'h0) begin
         fails++;
         $display("FAIL rst_wait_late_ack: reqs=%0d out=%h busy=%b, want 0 0 0",
                  reqs, out, busy);
      end
      model_clear();
      stab_err = 0;
   endtask

   task automatic test_retrig_enable();
      aq_t ea;
      logic [15:0] eo;
      logic [3:0] eb;
      int reqs = 0;
      do_reset();
      for (int i = 0; i < 4; i++) mem[16'(16'h3000 + i)] = 8'(8'h31 + i);
      cfg(1, 16'h3000, 16'd4);
      pulse_trig(4'b0010);
      m_pend |= 4'b0010;
      for (int f = 0; f < 3; f++) begin
         seen.delete();
         tick_pulse();
         if (f == 1) begin
            wait_req();
            pulse_trig(4'b0010);
         end
         wait_done();
         model_frame(ea, eo, eb);
         if (f == 1) m_pend |= 4'b0010;
         tests++;
         if (!same_q(seen, ea) || out !== eo || busy !== eb) begin
            fails++;
            $display("FAIL retrig_f%0d: addr=%p out=%h busy=%b, want addr=%p out=%h busy=%b",
                     f, seen, out, busy, ea, eo, eb);
         end
      end
      stall = 1;
      tick_pulse();
      wait_req();
      sound_enable = 1'b0;
      cyc(2);
      tests++;
      if (busy !== 4'h0 || out !== 16'h0 || mem_req !== 1'b1) begin
         fails++;
         $display("FAIL mute_pending: busy=%b out=%h req=%b, want 0 0 1", busy, out, mem_req);
      end
      stall = 0;
      cyc(6);
      for (int i = 0; i < 4; i++) begin
         pulse_trig(4'b0010);
         tick_pulse();
         for (int k = 0; k < 8; k++) begin
            cyc(1);
            if (mem_req) reqs++;
         end
      end
      tests++;
      if (reqs != 0 || mem_req !== 1'b0 || busy !== 4'h0 || out !== 16'h0 || overrun !== 1'b0) begin
         fails++;
         $display("FAIL mute_quiet: reqs=%0d req=%b busy=%b out=%h ovr=%b, want all 0",
                  reqs, mem_req, busy, out, overrun);
      end
      m_act = '0;
      m_pend = '0;
      sound_enable = 1'b1;
      cyc(1);
      pulse_trig(4'b0010);
      m_pend |= 4'b0010;
      run_frame();
      model_frame(ea, eo, eb);
      tests++;
      if (!same_q(seen, ea) || out !== eo || busy !== eb) begin
         fails++;
         $display("FAIL unmute_restart: addr=%p out=%h busy=%b, want addr=%p out=%h busy=%b",
                  seen, out, busy, ea, eo, eb);
      end
   endtask

   task automatic test_boundary();
      aq_t ea;
      logic [15:0] eo;
      logic [3:0] eb;
      logic [15:0] kaddr [2] = '{16'hFFFF, 16'h0000};
      do_reset();
      cfg(3, 16'h7000, 16'd0);
      pulse_trig(4'b1000);
      m_pend |= 4'b1000;
      run_frame();
      model_frame(ea, eo, eb);
      tests++;
      if (!same_q(seen, ea) || busy !== eb || seen.size() != 0 || busy[3] !== 1'b0) begin
         fails++;
         $display("FAIL len0: addr=%p busy=%b, want addr=%p busy=%b", seen, busy, ea, eb);
      end
      mem[16'hFFFF] = 8'h11;
      mem[16'h0000] = 8'h22;
      cfg(0, 16'hFFFF, 16'd2);
      pulse_trig(4'b0001);
      m_pend |= 4'b0001;
      for (int f = 0; f < 2; f++) begin
         run_frame();
         model_frame(ea, eo, eb);
         tests++;
         if (!same_q(seen, ea) || out !== eo || busy !== eb ||
             seen.size() != 1 || seen[0] !== kaddr[f]) begin
            fails++;
            $display("FAIL wrap_f%0d: addr=%p out=%h busy=%b, want addr=%p out=%h busy=%b",
                     f, seen, out, busy, ea, eo, eb);
         end
      end
   endtask

   task automatic test_random();
      aq_t ea;
      logic [15:0] eo;
      logic [3:0] eb;
      logic [3:0] mask;
      do_reset();
      for (int f = 0; f < 40; f++) begin
         if ($urandom_range(0, 2) == 0) begin
            cfg(int'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                            : 16'($urandom),
                16'($urandom_range(0, 5)));
         end
         loop = 4'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            mask = 4'($urandom);
            pulse_trig(mask);
            m_pend |= mask;
         end
         ack_dly = int'($urandom_range(1, 4));
         run_frame();
         model_frame(ea, eo, eb);
         tests++;
         if (!same_q(seen, ea) || out !== eo || busy !== eb) begin
            fails++;
            $display("FAIL random_f%0d: addr=%p out=%h busy=%b, want addr=%p out=%h busy=%b",
                     f, seen, out, busy, ea, eo, eb);
         end
      end
      tests++;
      if (overrun !== 1'b0 || stab_err != 0) begin
         fails++;
         $display("FAIL random_overrun: ovr=%b unstable=%0d, want 0 0", overrun, stab_err);
      end
   endtask

   initial begin
      rst = 1'b1; tick = 1'b0; sound_enable = 1'b1;
      trig = '0; loop = '0; cfg_wr = 1'b0;
      cfg_voice = '0; cfg_start = '0; cfg_len = '0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      test_reset();
      test_single_voice();
      test_loop();
      test_full_mix();
      test_overrun();
      test_rst_wait();
      test_retrig_enable();
      test_boundary();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
